// File: rtl/park_pkg.sv
`default_nettype none
// ============================================================================
// Module      : park_pkg
// Description : Shared definitions for the smart parking system. Holds the
//               default slot count and token width, the entry controller
//               state encoding, and the token type. The exit-side location
//               decoder imports the same token type.
// Revision    : 1.0 - initial release
// ============================================================================
package park_pkg;

    localparam int SLOTS_DEFAULT   = 8;
    localparam int TOKEN_W_DEFAULT = 3;

    // Entry controller states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        REJECT = 2'd2,
        HOLD   = 2'd3
    } park_state_t;

    // Slot index carried by a car between entry and exit
    typedef logic [TOKEN_W_DEFAULT-1:0] token_t;

endpackage : park_pkg
`default_nettype wire

// File: rtl/free_slot_finder.sv
`default_nettype none
// ============================================================================
// Module      : free_slot_finder
// Description : Combinational priority encoder over the occupancy vector.
//               Returns the lowest-numbered free slot and a flag that is set
//               when every slot is taken (free_idx is 0 in that case).
// Ports       : occupancy  in  [SLOTS-1:0]   bit i=1 means slot i is taken
//               free_idx   out [TOKEN_W-1:0] lowest free slot index
//               none_free  out               no slot is free
// Revision    : 1.0 - initial release
// ============================================================================
module free_slot_finder
    import park_pkg::*;
#(
    parameter int SLOTS   = SLOTS_DEFAULT,
    parameter int TOKEN_W = TOKEN_W_DEFAULT
) (
    input  logic [SLOTS-1:0]   occupancy,
    output logic [TOKEN_W-1:0] free_idx,
    output logic               none_free
);

    // Scan from the top down so the last hit, the lowest free index, wins
    always_comb begin
        free_idx  = '0;
        none_free = 1'b1;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) begin
                free_idx  = TOKEN_W'(i);
                none_free = 1'b0;
            end
        end
    end

endmodule : free_slot_finder
`default_nettype wire

// File: rtl/enter_park_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : enter_park_ctrl
// Description : Entry-side controller of the smart parking system. Owns the
//               occupancy map, allocates the lowest free slot on an entry
//               request and issues its index as the car's token, and frees
//               the slot named by an exit token.
// Ports       : clk            in   system clock, rising edge
//               rst            in   asynchronous active-high reset
//               enter          in   entry request level, held until answered
//               exit           in   single-cycle exit qualifier
//               exit_token     in   [TOKEN_W-1:0] slot being vacated
//               grant          out  one-cycle pulse, slot allocated
//               reject         out  one-cycle pulse, lot full
//               token          out  [TOKEN_W-1:0] allocated slot index
//               park_location  out  [SLOTS-1:0] occupancy map
//               full           out  every slot taken (combinational)
//               exit_err       out  one-cycle pulse, exit of a free slot
//               free_cnt       out  [TOKEN_W:0] free slot count
//                                   (only with ENTER_PARK_COUNT_EN defined)
// Config      : ENTER_PARK_COUNT_EN - adds the registered free slot counter
// Revision    : 1.0 - initial release
// ============================================================================
module enter_park_ctrl
    import park_pkg::*;
#(
    parameter int SLOTS   = SLOTS_DEFAULT,
    parameter int TOKEN_W = TOKEN_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enter,
    input  logic               exit,
    input  logic [TOKEN_W-1:0] exit_token,
    output logic               grant,
    output logic               reject,
    output logic [TOKEN_W-1:0] token,
    output logic [SLOTS-1:0]   park_location,
    output logic               full,
`ifdef ENTER_PARK_COUNT_EN
    output logic               exit_err,
    output logic [TOKEN_W:0]   free_cnt
`else
    output logic               exit_err
`endif
);

    localparam logic [SLOTS-1:0] c_one_hot0 = SLOTS'(1);

    park_state_t        r_state;
    logic               r_grant;
    logic               r_reject;
    logic               r_exit_err;
    logic [TOKEN_W-1:0] r_token;
    logic [SLOTS-1:0]   r_map;

    logic [TOKEN_W-1:0] w_free_idx;
    logic               w_none_free;
    logic               w_alloc;
    logic               w_exit_ok;
    logic [SLOTS-1:0]   w_alloc_mask;
    logic [SLOTS-1:0]   w_exit_mask;
    logic [SLOTS-1:0]   w_map_next;

    free_slot_finder #(
        .SLOTS   (SLOTS),
        .TOKEN_W (TOKEN_W)
    ) u_free_slot_finder (
        .occupancy (r_map),
        .free_idx  (w_free_idx),
        .none_free (w_none_free)
    );

    // Allocation and exit both look at the pre-edge map. An allocated slot
    // was free and an exit of a free slot is dropped, so the two masks can
    // never hit the same bit.
    assign w_alloc      = (r_state == IDLE) && enter && !w_none_free;
    assign w_exit_ok    = exit && r_map[exit_token];
    assign w_alloc_mask = w_alloc   ? (c_one_hot0 << w_free_idx) : '0;
    assign w_exit_mask  = w_exit_ok ? (c_one_hot0 << exit_token) : '0;
    assign w_map_next   = (r_map & ~w_exit_mask) | w_alloc_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= 1'b0;
            r_reject   <= 1'b0;
            r_exit_err <= 1'b0;
            r_token    <= '0;
            r_map      <= '0;
        end else begin
            r_grant    <= 1'b0;
            r_reject   <= 1'b0;
            r_exit_err <= exit && !r_map[exit_token];
            r_map      <= w_map_next;
            case (r_state)
                IDLE: begin
                    if (enter) begin
                        if (w_none_free) begin
                            r_reject <= 1'b1;
                            r_state  <= REJECT;
                        end else begin
                            r_grant  <= 1'b1;
                            r_token  <= w_free_idx;
                            r_state  <= GRANT;
                        end
                    end
                end
                GRANT, REJECT: r_state <= HOLD;
                // One allocation per request: wait for the gate to drop enter
                HOLD: begin
                    if (!enter) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant         = r_grant;
    assign reject        = r_reject;
    assign token         = r_token;
    assign park_location = r_map;
    assign exit_err      = r_exit_err;
    assign full          = &r_map;

`ifdef ENTER_PARK_COUNT_EN
    localparam logic [TOKEN_W:0] c_slots_cnt = (TOKEN_W + 1)'(SLOTS);

    logic [TOKEN_W:0] r_free_cnt;

    // A grant and a valid exit on the same edge cancel out; the bounds
    // guard against wrap even though the map logic keeps the count legal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_free_cnt <= c_slots_cnt;
        end else if (w_alloc && !w_exit_ok && (r_free_cnt != '0)) begin
            r_free_cnt <= r_free_cnt - 1'b1;
        end else if (w_exit_ok && !w_alloc && (r_free_cnt != c_slots_cnt)) begin
            r_free_cnt <= r_free_cnt + 1'b1;
        end
    end

    assign free_cnt = r_free_cnt;
`endif

endmodule : enter_park_ctrl
`default_nettype wire

// File: doc/enter_park_ctrl.md
# enter_park_ctrl

Entry-side controller for the smart parking system. It owns the occupancy map. On a car's entry request it allocates the lowest-numbered free slot and issues that slot's index as the car's token. It also accepts exit requests carrying a token and frees the matching slot. It is the counterpart of the exit-side location decoder and drives the same one-hot-per-slot occupancy vector.

## Interface
Parameters:
- SLOTS, 8, number of parking slots; must be a power of two, 2..8
- TOKEN_W, 3, token width; must equal log2(SLOTS)

Ports:
- clk  input  1  single system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- enter  input  1  entry request, level; held by the gate until a grant or reject is seen
- exit  input  1  exit request, single-cycle qualifier for exit_token
- exit_token  input  TOKEN_W  slot index being vacated
- grant  output  1  one-cycle pulse: slot allocated
- reject  output  1  one-cycle pulse: lot full, no slot allocated
- token  output  TOKEN_W  allocated slot index; valid while grant=1, holds its value afterwards
- park_location  output  SLOTS  occupancy map; bit i=1 means slot i is taken
- full  output  1  all park_location bits are set
- exit_err  output  1  one-cycle pulse: exit issued for a slot that was already free

## Operation
- FSM states: IDLE, GRANT, REJECT, HOLD.
- IDLE:
  - enter=1 and not full → GRANT.
  - enter=1 and full → REJECT.
  - Otherwise stay in IDLE.
- Entering GRANT:
  - token is loaded with the lowest index i where park_location[i]=0.
  - park_location[i] is set on the same edge.
  - grant=1 for that cycle.
- REJECT: reject=1 for one cycle; park_location is unchanged.
- GRANT and REJECT always go to HOLD on the next edge.
- HOLD: stays until enter=0, then returns to IDLE. This gives one allocation per request, with no repeat allocation while enter stays high.
- Exit, independent of the FSM and accepted in every state:
  - exit=1 and park_location[exit_token]=1 → the bit is cleared on the edge.
  - exit=1 and park_location[exit_token]=0 → exit_err pulses on the next cycle; the map is unchanged.
- Simultaneous allocation and exit in one cycle:
  - The full check and the free-slot search use the pre-edge map.
  - Both updates are applied.
  - If the lot was full, the request is rejected even though a slot frees on that same edge.
  - The allocated slot can never equal exit_token, because the allocated slot was free and a free-slot exit is an error.
- full is combinational from park_location.

## Timing
- Reset values: FSM=IDLE; grant=0, reject=0, exit_err=0; token=0; park_location=0; full=0.
- Reset asserted mid-operation immediately clears all state, including any grant that is in progress.
- Entry latency: enter rising in IDLE at edge N → grant or reject high during the cycle after edge N+1; park_location is updated at edge N+1.
- Exit latency: the park_location bit clears at the first edge with exit=1; exit_err is registered and goes high one cycle after that edge.
- Minimum spacing between allocations is 3 cycles: GRANT, HOLD with enter dropped, IDLE.

## Configuration
- Macro ENTER_PARK_COUNT_EN.
  - Defined: adds output free_cnt [TOKEN_W:0], a registered count of free slots.
    - Reset value is SLOTS.
    - Decremented on grant and incremented on a valid exit.
    - Unchanged when both happen on the same edge.
    - Never wraps; it is bounded to 0..SLOTS.
  - Undefined: no port and no counter logic is present.

## Structure
- Shared package park_pkg holds:
  - SLOTS_DEFAULT and TOKEN_W_DEFAULT constants
  - the state enum (IDLE, GRANT, REJECT, HOLD)
  - the token typedef, which the exit-side decoder also uses
- One sub-module, free_slot_finder: a combinational priority encoder taking the occupancy vector and producing the lowest free index plus a none_free flag.

## Test plan
- Reset, then enter held for 10 cycles → exactly one grant pulse, token=0, park_location=8'b0000_0001, HOLD maintained; enter drop then re-raise → token=1, park_location=8'b0000_0011.
- Eight sequential entries → tokens 0..7 in order, full=1 after the eighth; ninth entry → reject pulse, no grant, map stays 8'hFF.
- Map 8'hFF, exit with token 3'b010 → map 8'hFB; next entry → token=2.
- Map 8'hFF, entry and exit token 3'b101 in the same cycle → reject, map 8'hDF after the edge; next entry → token=5.
- Exit with token 3'b100 on an empty map → exit_err pulses one cycle later, map remains 8'h00; with ENTER_PARK_COUNT_EN, free_cnt stays 8.
- Reset asserted the cycle grant is high with map 8'h07 → all outputs return to reset values asynchronously; map 8'h00.
